cube_array_generator: RTL and testbench

Parametrised successor of the single-cube face generator. It classifies each VGA/MTL pixel against a table of up to NCUBES isometric cubes and returns the front-most face hit, with a fixed pipeline latency. It also tracks Q*bert landings per cube with a dwell-time FSM and reports when every cube has been visited. It sits between the pixel counter and the colour mux of the display pipeline.

---
 rtl/cube_pkg.sv | 24 ++
 rtl/cube_face_test.sv | 34 +++
 rtl/cube_array_generator.sv | 207 ++++++++++++++++++++
 tb/tb_cube_array_generator.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// Shared types, widths and offset helpers for the cube array generator.
package cube_pkg;
   localparam int XW = 11;
   localparam int YW = 10;
   localparam int SW = 13;   // signed offset width
   localparam int PW = 24;   // product width, wide enough for every term

   typedef enum logic [1:0] {FACE_NONE, FACE_TOP, FACE_LEFT, FACE_RIGHT} face_t;
   typedef enum logic [1:0] {ST_IDLE, ST_DWELL, ST_LANDED} dwell_state_t;

   typedef struct packed {
      logic          en;
      logic [XW-1:0] cx;
      logic [YW-1:0] cy;
   } cube_cfg_t;

   function automatic logic signed [SW-1:0] soff(input logic [XW-1:0] p, input logic [XW-1:0] c);
      return $signed({2'b00, p}) - $signed({2'b00, c});
   endfunction

   function automatic logic [SW-1:0] sabs(input logic signed [SW-1:0] v);
      return v[SW-1] ? SW'(-v) : SW'(v);
   endfunction
endpackage

// File: rtl/cube_face_test.sv
// Combinational isometric cube test on a point given as its offset from the cube centre
// (sign of dx, dy, a=|dx|); returns the top-face hit and the side-face code.
module cube_face_test
   import cube_pkg::*;
(
   input  logic                 dx_neg,
   input  logic signed [SW-1:0] dy,
   input  logic [SW-1:0]        a,
   input  logic [XW-1:0]        half_w,
   input  logic [YW-1:0]        half_h,
   input  logic [YW-1:0]        side_len,
   output logic                 top_hit,
   output face_t                side
);
   logic [SW-1:0] ady;
   logic [PW-1:0] w, h, l, dyw, lo, hi;
   logic          side_hit;

   always_comb begin
      ady     = sabs(dy);
      w       = PW'(half_w);
      h       = PW'(half_h);
      l       = PW'(side_len);
      dyw     = PW'(ady) * w;
      top_hit = (PW'(a) * h + dyw) <= (w * h);
      // lo is only meaningful when a<=W, which gates the side hit
      lo       = h * (w - PW'(a));
      hi       = lo + l * w;
      side_hit = !dy[SW-1] && (PW'(a) <= w) && (dyw > lo) && (dyw <= hi);
      if (!side_hit)   side = FACE_NONE;
      else if (dx_neg) side = FACE_LEFT;
      else             side = FACE_RIGHT;
   end
endmodule

// File: rtl/cube_array_generator.sv
// Three-stage pixel classifier over a double-buffered cube table; the Q*bert landing
// tracker (scanner, dwell FSM, visited flags) is built only with CUBE_QBERT_TRACK_EN.
module cube_array_generator
   import cube_pkg::*;
#(
   parameter int NCUBES = 28,
   parameter int IDXW   = (NCUBES > 1) ? $clog2(NCUBES) : 1,
   parameter int DWELL  = 65536
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            frame_start,
   input  logic [XW-1:0]   x_cnt,
   input  logic [YW-1:0]   y_cnt,
   input  logic [XW-1:0]   half_w,
   input  logic [YW-1:0]   half_h,
   input  logic [YW-1:0]   side_len,
   input  logic            cfg_we,
   input  logic [IDXW-1:0] cfg_idx,
   input  logic [XW-1:0]   cfg_cx,
   input  logic [YW-1:0]   cfg_cy,
   input  logic            cfg_en,
   input  logic [XW-1:0]   qbert_x,
   input  logic [YW-1:0]   qbert_y,
   input  logic            clear_visited,
   output logic [1:0]      face,
   output logic [IDXW-1:0] face_idx,
   output logic            face_visited,
   output logic [IDXW-1:0] qbert_on_idx,
   output logic            qbert_on,
   output logic            all_visited
);
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

   cube_cfg_t shadow_q [NCUBES], shadow_d [NCUBES];
   cube_cfg_t active_q [NCUBES], active_d [NCUBES];

   logic [NCUBES-1:0]          s1_neg_q, s1_neg_d, s1_en_q, s1_en_d;
   logic [NCUBES-1:0][SW-1:0]  s1_dy_q, s1_dy_d, s1_a_q, s1_a_d;
   logic [NCUBES-1:0]          top_c, s2_top_q, s2_top_d;
   logic [NCUBES-1:0][1:0]     s2_side_q, s2_side_d;
   face_t                      side_c [NCUBES];
   face_t                      face_d;
   logic [1:0]                 face_q;
   logic [IDXW-1:0]            face_idx_q, face_idx_d;
   logic                       face_visited_q, face_visited_d;
   logic [NCUBES-1:0]          visited_w;
   logic signed [SW-1:0]       dx_t;

   // A write in the frame_start cycle lands in the shadow only; the commit takes the old shadow.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (frame_start) active_d = shadow_q;
      if (cfg_we && (32'(cfg_idx) < NCUBES))
         shadow_d[cfg_idx] = '{en: cfg_en, cx: cfg_cx, cy: cfg_cy};
   end

   always_comb begin
      dx_t = '0;
      for (int i = 0; i < NCUBES; i++) begin
         dx_t        = soff(x_cnt, active_q[i].cx);
         s1_neg_d[i] = dx_t[SW-1];
         s1_a_d[i]   = sabs(dx_t);
         s1_dy_d[i]  = soff(XW'(y_cnt), XW'(active_q[i].cy));
         s1_en_d[i]  = active_q[i].en;
         s2_top_d[i]  = s1_en_q[i] && top_c[i];
         s2_side_d[i] = s1_en_q[i] ? side_c[i] : FACE_NONE;
      end
   end

   for (genvar g = 0; g < NCUBES; g++) begin : g_cube
      cube_face_test u_test (
         .dx_neg(s1_neg_q[g]), .dy(s1_dy_q[g]), .a(s1_a_q[g]),
         .half_w, .half_h, .side_len,
         .top_hit(top_c[g]), .side(side_c[g])
      );
   end

   // Ascending scan: the last hitting slot is the highest index, which wins.
   always_comb begin
      face_d     = FACE_NONE;
      face_idx_d = '0;
      for (int i = 0; i < NCUBES; i++) begin
         if (s2_top_q[i] || (s2_side_q[i] != 2'b00)) begin
            face_idx_d = IDXW'(i);
            face_d     = s2_top_q[i] ? FACE_TOP : face_t'(s2_side_q[i]);
         end
      end
      face_visited_d = (face_d != FACE_NONE) && visited_w[face_idx_d];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NCUBES; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         s1_neg_q <= '0; s1_en_q <= '0; s1_dy_q <= '0; s1_a_q <= '0;
         s2_top_q <= '0; s2_side_q <= '0;
         face_q <= '0; face_idx_q <= '0; face_visited_q <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         s1_neg_q <= s1_neg_d; s1_en_q <= s1_en_d; s1_dy_q <= s1_dy_d; s1_a_q <= s1_a_d;
         s2_top_q <= s2_top_d; s2_side_q <= s2_side_d;
         face_q <= face_d; face_idx_q <= face_idx_d; face_visited_q <= face_visited_d;
      end
   end

   assign face         = face_q;
   assign face_idx     = face_idx_q;
   assign face_visited = face_visited_q;

`ifdef CUBE_QBERT_TRACK_EN
   logic [IDXW-1:0]      scan_idx_q, scan_idx_d, sweep_idx_q, sweep_idx_d;
   logic                 sweep_hit_q, sweep_hit_d, cand_q, cand_d;
   logic [IDXW-1:0]      cand_idx_q, cand_idx_d, dw_idx_q, dw_idx_d;
   dwell_state_t         st_q, st_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [NCUBES-1:0]    visited_q, visited_d, en_w;
   logic                 all_vis_q, all_vis_d, set_vis, scan_top, scan_hit, last_slot;
   logic signed [SW-1:0] q_dx, q_dy;
   logic [SW-1:0]        q_a;
   cube_cfg_t            scan_cfg;
   face_t                scan_side_unused;

   always_comb begin
      scan_cfg = active_q[scan_idx_q];
      q_dx     = soff(qbert_x, scan_cfg.cx);
      q_dy     = soff(XW'(qbert_y), XW'(scan_cfg.cy));
      q_a      = sabs(q_dx);
   end

   cube_face_test u_scan (
      .dx_neg(q_dx[SW-1]), .dy(q_dy), .a(q_a),
      .half_w, .half_h, .side_len,
      .top_hit(scan_top), .side(scan_side_unused)
   );

   always_comb begin
      scan_hit    = scan_cfg.en && scan_top;
      last_slot   = (scan_idx_q == IDXW'(NCUBES - 1));
      scan_idx_d  = last_slot ? '0 : scan_idx_q + 1'b1;
      sweep_hit_d = sweep_hit_q | scan_hit;
      sweep_idx_d = scan_hit ? scan_idx_q : sweep_idx_q;
      cand_d      = cand_q;
      cand_idx_d  = cand_idx_q;
      if (last_slot) begin
         cand_d      = sweep_hit_d;
         cand_idx_d  = sweep_idx_d;
         sweep_hit_d = 1'b0;
         sweep_idx_d = '0;
      end

      st_d     = st_q;
      dw_idx_d = dw_idx_q;
      cnt_d    = cnt_q;
      set_vis  = 1'b0;
      case (st_q)
         ST_IDLE: if (cand_q) begin
            st_d     = ST_DWELL;
            dw_idx_d = cand_idx_q;
            cnt_d    = '0;
         end
         ST_DWELL:
            if (!cand_q || (cand_idx_q != dw_idx_q)) st_d = ST_IDLE;
            else if (cnt_q == CW'(DWELL - 1)) begin
               st_d    = ST_LANDED;
               set_vis = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
         ST_LANDED: if (!cand_q || (cand_idx_q != dw_idx_q)) st_d = ST_IDLE;
         default: st_d = ST_IDLE;
      endcase

      visited_d = visited_q;
      if (set_vis)       visited_d[dw_idx_q] = 1'b1;
      if (clear_visited) visited_d = '0;
      for (int i = 0; i < NCUBES; i++) en_w[i] = active_q[i].en;
      all_vis_d = (|en_w) && (&(visited_q | ~en_w));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_idx_q <= '0; sweep_idx_q <= '0; sweep_hit_q <= 1'b0;
         cand_q <= 1'b0; cand_idx_q <= '0; dw_idx_q <= '0;
         st_q <= ST_IDLE; cnt_q <= '0; visited_q <= '0; all_vis_q <= 1'b0;
      end else begin
         scan_idx_q <= scan_idx_d; sweep_idx_q <= sweep_idx_d; sweep_hit_q <= sweep_hit_d;
         cand_q <= cand_d; cand_idx_q <= cand_idx_d; dw_idx_q <= dw_idx_d;
         st_q <= st_d; cnt_q <= cnt_d; visited_q <= visited_d; all_vis_q <= all_vis_d;
      end
   end

   assign visited_w    = visited_q;
   assign qbert_on     = cand_q;
   assign qbert_on_idx = cand_idx_q;
   assign all_visited  = all_vis_q;
`else
   logic [CW+XW+YW:0] unused_trk;
   assign unused_trk   = {CW'(DWELL - 1), qbert_x, qbert_y, clear_visited};
   assign visited_w    = '0;
   assign qbert_on     = 1'b0;
   assign qbert_on_idx = '0;
   assign all_visited  = 1'b0;
`endif
endmodule

// File: tb/tb_cube_array_generator.sv
// Directed bench: pixel expectations go through a 3-cycle scoreboard; tracker steps are polled.
module tb_cube_array_generator;
   import cube_pkg::*;

   localparam int NC = 4;
   localparam int IW = 2;
   localparam int DW = 16;

   logic          clk = 1'b0, reset = 1'b0, frame_start = 1'b0;
   logic [10:0]   x_cnt = '0, half_w = '0, cfg_cx = '0, qbert_x = '0;
   logic [9:0]    y_cnt = '0, half_h = '0, side_len = '0, cfg_cy = '0, qbert_y = '0;
   logic          cfg_we = 1'b0, cfg_en = 1'b0, clear_visited = 1'b0;
   logic [IW-1:0] cfg_idx = '0;
   logic [1:0]    face;
   logic [IW-1:0] face_idx, qbert_on_idx;
   logic          face_visited, qbert_on, all_visited;

   always #5 clk = ~clk;

   cube_array_generator #(.NCUBES(NC), .IDXW(IW), .DWELL(DW)) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start), .x_cnt(x_cnt), .y_cnt(y_cnt),
      .half_w(half_w), .half_h(half_h), .side_len(side_len), .cfg_we(cfg_we),
      .cfg_idx(cfg_idx), .cfg_cx(cfg_cx), .cfg_cy(cfg_cy), .cfg_en(cfg_en),
      .qbert_x(qbert_x), .qbert_y(qbert_y), .clear_visited(clear_visited),
      .face(face), .face_idx(face_idx), .face_visited(face_visited),
      .qbert_on_idx(qbert_on_idx), .qbert_on(qbert_on), .all_visited(all_visited)
   );

   typedef struct {
      logic [1:0]    face;
      logic [IW-1:0] idx;
      string         tag;
   } exp_t;

   exp_t       sb[$];
   logic [2:0] vld = '0;
   logic       drv = 1'b0;
   logic       ok;
   int         n_pass = 0, n_chk = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      cfg_we      = 1'b0;
      vld         = {vld[1:0], drv};
      drv         = 1'b0;
      if (vld[2]) begin
         e = sb.pop_front();
         chk({e.tag, ".face"}, 32'(face), 32'(e.face));
         chk({e.tag, ".idx"},  32'(face_idx), 32'(e.idx));
         chk({e.tag, ".vis"},  32'(face_visited), 32'(0));
      end
   endtask

   task automatic px(input int x, input int y, input int f, input int i, input string tag);
      exp_t e;
      x_cnt = 11'(x);
      y_cnt = 10'(y);
      drv   = 1'b1;
      e.face = 2'(f);
      e.idx  = IW'(i);
      e.tag  = tag;
      sb.push_back(e);
   endtask

   task automatic cfg(input int idx, input int cx, input int cy, input logic en);
      cfg_we  = 1'b1;
      cfg_idx = IW'(idx);
      cfg_cx  = 11'(cx);
      cfg_cy  = 10'(cy);
      cfg_en  = en;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".face"},    32'(face), 32'(0));
      chk({tag, ".idx"},     32'(face_idx), 32'(0));
      chk({tag, ".fvis"},    32'(face_visited), 32'(0));
      chk({tag, ".qon"},     32'(qbert_on), 32'(0));
      chk({tag, ".qidx"},    32'(qbert_on_idx), 32'(0));
      chk({tag, ".allvis"},  32'(all_visited), 32'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset    = 1'b1;
      half_w   = 11'd40;
      half_h   = 10'd20;
      side_len = 10'd40;

      // single cube, faces and boundaries
      cfg(0, 100, 100, 1'b1); step();
      frame_start = 1'b1; step();
      px(100, 100, 1, 0, "top_c0");       step();
      px(80, 130, 2, 0, "left_c0");       step();
      px(120, 130, 3, 0, "right_c0");     step();
      px(100, 165, 0, 0, "below_c0");     step();
      px(100, 80, 1, 0, "top_vertex");    step();
      px(140, 100, 1, 0, "top_east_edge"); step();
      px(141, 100, 0, 0, "outside_east"); step();
      px(100, 160, 3, 0, "side_bottom");  step();
      px(100, 161, 0, 0, "past_bottom");  step();
      repeat (3) step();

      // overlapping cubes: higher index wins
      cfg(1, 100, 100, 1'b1); step();
      frame_start = 1'b1; step();
      px(100, 100, 1, 1, "prio_top");  step();
      px(80, 130, 2, 1, "prio_left");  step();

      // write coinciding with frame_start stays in the shadow
      cfg(2, 300, 200, 1'b1); frame_start = 1'b1;
      px(300, 200, 0, 0, "coincident_we"); step();
      px(300, 200, 0, 0, "not_committed"); step();
      repeat (4) step();
      px(300, 200, 0, 0, "shadow_only");   step();
      frame_start = 1'b1;
      px(300, 200, 0, 0, "fs_same_cycle"); step();
      px(300, 200, 1, 2, "committed");     step();

      // disabled slot is ignored
      cfg(1, 100, 100, 1'b0); step();
      frame_start = 1'b1; step();
      px(100, 100, 1, 0, "disabled_slot"); step();
      repeat (3) step();

`ifdef CUBE_QBERT_TRACK_EN
      // only cube 2 enabled: landing sets the flag and all_visited
      cfg(0, 100, 100, 1'b0); step();
      frame_start = 1'b1; step();
      qbert_x = 11'd300; qbert_y = 10'd200;
      x_cnt = 11'd300;   y_cnt = 10'd200;
      ok = 1'b0;
      for (int k = 0; k < 3 * NC + 4 && !ok; k++) begin step(); ok = qbert_on; end
      chk("qbert_on_c2", 32'(qbert_on), 32'(1));
      chk("qbert_idx_c2", 32'(qbert_on_idx), 32'(2));
      repeat (8) step();
      chk("no_early_land", 32'(face_visited), 32'(0));
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin step(); ok = face_visited; end
      chk("landed_c2", 32'(ok), 32'(1));
      repeat (2) step();
      chk("all_vis_single", 32'(all_visited), 32'(1));

      // clear held across a fresh landing keeps every flag clear
      clear_visited = 1'b1;
      qbert_x = 11'd600; qbert_y = 10'd400;
      repeat (12) step();
      qbert_x = 11'd300; qbert_y = 10'd200;
      repeat (40) step();
      clear_visited = 1'b0;
      repeat (2) step();
      chk("clear_wins.fvis", 32'(face_visited), 32'(0));
      chk("clear_wins.allvis", 32'(all_visited), 32'(0));

      // leave a cube before DWELL expires: no flag
      cfg(0, 100, 100, 1'b1); step();
      cfg(1, 100, 100, 1'b1); step();
      frame_start = 1'b1; step();
      qbert_x = 11'd100; qbert_y = 10'd100;
      ok = 1'b0;
      for (int k = 0; k < 3 * NC + 4 && !ok; k++) begin step(); ok = qbert_on && (qbert_on_idx == 2'd1); end
      chk("qbert_on_c1", 32'(ok), 32'(1));
      repeat (6) step();
      qbert_x = 11'd600; qbert_y = 10'd400;
      repeat (30) step();
      chk("moved_away.qon", 32'(qbert_on), 32'(0));
      x_cnt = 11'd100; y_cnt = 10'd100;
      repeat (4) step();
      chk("moved_away.idx", 32'(face_idx), 32'(1));
      chk("moved_away.fvis", 32'(face_visited), 32'(0));

      // reset mid-dwell, then a full re-dwell is needed
      qbert_x = 11'd100; qbert_y = 10'd100;
      ok = 1'b0;
      for (int k = 0; k < 3 * NC + 4 && !ok; k++) begin step(); ok = qbert_on; end
      chk("redwell_start", 32'(ok), 32'(1));
      repeat (5) step();
      reset = 1'b0;
      #1;
      check_all_zero("mid_dwell_reset");
      repeat (2) step();
      reset = 1'b1;
      cfg(1, 100, 100, 1'b1); step();
      frame_start = 1'b1; step();
      ok = 1'b0;
      for (int k = 0; k < 3 * NC + 4 && !ok; k++) begin step(); ok = qbert_on; end
      chk("redwell_on", 32'(ok), 32'(1));
      repeat (12) step();
      chk("redwell_not_early", 32'(face_visited), 32'(0));
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin step(); ok = face_visited; end
      chk("redwell_landed", 32'(ok), 32'(1));
`else
      // tracker absent: outputs tied low while the pixel path still works
      qbert_x = 11'd300; qbert_y = 10'd200;
      x_cnt = 11'd300;   y_cnt = 10'd200;
      repeat (40) step();
      chk("notrk.face", 32'(face), 32'(1));
      chk("notrk.idx", 32'(face_idx), 32'(2));
      chk("notrk.fvis", 32'(face_visited), 32'(0));
      chk("notrk.qon", 32'(qbert_on), 32'(0));
      chk("notrk.qidx", 32'(qbert_on_idx), 32'(0));
      chk("notrk.allvis", 32'(all_visited), 32'(0));
      reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      repeat (2) step();
      reset = 1'b1;
      px(300, 200, 0, 0, "table_cleared"); step();
      repeat (3) step();
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
